// File: rtl/mfp_fifo_rd_stream.sv
// rtl/mfp_fifo_rd_stream.sv - burst reader: pops CMD_LEN+1 FIFO words into a 2-deep output stream.
// Optional completed-burst counter enabled by defining MFP_FIFO_RD_STREAM_CNT_EN.
module mfp_fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    output logic                  FIFO_REN,
    input  logic [DATA_WIDTH-1:0] FIFO_RDATA,
    input  logic                  FIFO_REMPTY,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_LAST,
    output logic [15:0]           BURST_CNT
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [LEN_WIDTH:0] ONE = (LEN_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_WIDTH:0]    r_pop_left;
    logic [LEN_WIDTH:0]    r_out_left;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_buf0_data;
    logic [DATA_WIDTH-1:0] r_buf1_data;
    logic                  r_buf0_last;
    logic                  r_buf1_last;

    logic                  w_out_fire;
    logic                  w_cmd_acc;
    logic [2:0]            w_occ;
    logic                  w_wr_hi;

    assign w_out_fire = OUT_VALID & OUT_READY;
    assign w_cmd_acc  = CMD_READY & CMD_VALID;
    // Occupancy after this cycle's transfer; a pop is allowed only if its word will fit.
    assign w_occ      = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_out_fire};
    assign w_wr_hi    = (r_count == 2'd2) || ((r_count == 2'd1) && !w_out_fire);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (CMD_VALID) w_state_nxt = S_BURST;
            S_BURST: if (w_out_fire && (r_out_left == ONE)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        CMD_READY = !RST && (r_state == S_IDLE);
        OUT_VALID = !RST && (r_count != 2'd0);
        OUT_DATA  = RST ? '0 : r_buf0_data;
        OUT_LAST  = !RST && r_buf0_last;
        FIFO_REN  = !RST && (r_state == S_BURST) && (r_pop_left != '0)
                    && !FIFO_REMPTY && (w_occ < 3'd2);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pop_left      <= '0;
            r_out_left      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_count         <= 2'd0;
            r_buf0_data     <= '0;
            r_buf1_data     <= '0;
            r_buf0_last     <= 1'b0;
            r_buf1_last     <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_pop_left <= {1'b0, CMD_LEN} + ONE;
                r_out_left <= {1'b0, CMD_LEN} + ONE;
            end else begin
                if (FIFO_REN) r_pop_left <= r_pop_left - ONE;
                if (w_out_fire) r_out_left <= r_out_left - ONE;
            end
            r_inflight      <= FIFO_REN;
            r_inflight_last <= FIFO_REN && (r_pop_left == ONE);
            r_count         <= r_count + {1'b0, r_inflight} - {1'b0, w_out_fire};
            if (w_out_fire) begin
                r_buf0_data <= r_buf1_data;
                r_buf0_last <= r_buf1_last;
            end
            // The captured word lands behind whatever survives this cycle's transfer.
            if (r_inflight) begin
                if (w_wr_hi) begin
                    r_buf1_data <= FIFO_RDATA;
                    r_buf1_last <= r_inflight_last;
                end else begin
                    r_buf0_data <= FIFO_RDATA;
                    r_buf0_last <= r_inflight_last;
                end
            end
        end
    end

`ifdef MFP_FIFO_RD_STREAM_CNT_EN
    logic [15:0] r_burst_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_burst_cnt <= 16'd0;
        end else if (w_out_fire && r_buf0_last) begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
        end
    end

    assign BURST_CNT = r_burst_cnt;
`else
    assign BURST_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_mfp_fifo_rd_stream.sv
// tb/tb_mfp_fifo_rd_stream.sv - scoreboard bench for mfp_fifo_rd_stream with a behavioural FIFO.
module tb_mfp_fifo_rd_stream;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [3:0]  CMD_LEN;
    logic        FIFO_REN;
    logic [31:0] FIFO_RDATA;
    logic        FIFO_REMPTY;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_DATA;
    logic        OUT_LAST;
    logic [15:0] BURST_CNT;

    mfp_fifo_rd_stream dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_LEN(CMD_LEN), .FIFO_REN(FIFO_REN), .FIFO_RDATA(FIFO_RDATA),
        .FIFO_REMPTY(FIFO_REMPTY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST), .BURST_CNT(BURST_CNT)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wv(input logic [7:0] i);
        return {i, ~i, 8'h5A, i};
    endfunction

    // Behavioural FIFO: data appears on FIFO_RDATA the cycle after FIFO_REN.
    logic [31:0] mem [256];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    assign FIFO_REMPTY = (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (FIFO_REN) begin
            FIFO_RDATA <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 8'd1;
        end
    end

    task automatic push_word();
        mem[wr_ptr] = wv(wr_ptr);
        wr_ptr = wr_ptr + 8'd1;
    endtask

    logic [32:0] exp_q[$];

    // Monitor: scoreboard pop on transfer, occupancy bound, hold-while-stalled.
    int          outstanding = 0;
    logic        prev_hold = 1'b0;
    logic [32:0] prev_word;
    always @(negedge CLK) begin
        logic [32:0] e;
        if (RST) begin
            outstanding = 0;
            prev_hold   = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", OUT_VALID, 1'b1);
                check("hold_word", {OUT_LAST, OUT_DATA}, prev_word);
            end
            if (FIFO_REN) check("ren_while_empty", FIFO_REMPTY, 1'b0);
            if (OUT_VALID && OUT_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {OUT_LAST, OUT_DATA}, 33'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", OUT_DATA, e[31:0]);
                    check("out_last", OUT_LAST, e[32]);
                end
            end
            outstanding = outstanding + int'(FIFO_REN) - int'(OUT_VALID && OUT_READY);
            if (FIFO_REN) check("occupancy_le2", outstanding <= 2, 1'b1);
            prev_hold = OUT_VALID && !OUT_READY;
            prev_word = {OUT_LAST, OUT_DATA};
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_cmd(input int len);
        int n;
        CMD_LEN   = 4'(len);
        CMD_VALID = 1'b1;
        n = 0;
        while (!CMD_READY && n < 50) begin
            step();
            n++;
        end
        check("cmd_accept_timeout", n < 50, 1'b1);
        step();
        CMD_VALID = 1'b0;
    endtask

    int ren_n, ren_first, ren_last, fire_n, fire_first, fire_last;

    // rmode 0: OUT_READY high; rmode 1: pattern 1,0,0. late: words pushed after 5 idle cycles, every 3.
    task automatic run_burst(input int len, input int rmode, input int late);
        logic [7:0] base;
        int pushed;
        bit done;
        base = rd_ptr;
        for (int i = 0; i <= len; i++)
            exp_q.push_back({(i == len), wv(base + 8'(i))});
        ren_n = 0; fire_n = 0; ren_first = -1; fire_first = -1; ren_last = -1; fire_last = -1;
        pushed = 0;
        done = 1'b0;
        OUT_READY = 1'b1;
        issue_cmd(len);
        for (int k = 0; k < 300 && !done; k++) begin
            OUT_READY = (rmode == 0) ? 1'b1 : ((k % 3) == 0);
            if (pushed < late && k >= 5 && ((k - 5) % 3) == 0) begin
                push_word();
                pushed++;
            end
            @(negedge CLK);
            if (FIFO_REN) begin
                if (ren_first < 0) ren_first = k;
                ren_last = k;
                ren_n++;
            end
            if (OUT_VALID && OUT_READY) begin
                if (fire_first < 0) fire_first = k;
                fire_last = k;
                fire_n++;
            end
            step();
            if (CMD_READY) done = 1'b1;
        end
        check("burst_timeout", done, 1'b1);
        check("exp_left", exp_q.size(), 0);
        OUT_READY = 1'b1;
    endtask

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD_LEN = 4'd0; OUT_READY = 1'b1;
        step();
        step();
        check("rst_cmd_ready", CMD_READY, 1'b0);
        check("rst_ren", FIFO_REN, 1'b0);
        check("rst_valid", OUT_VALID, 1'b0);
        check("rst_last", OUT_LAST, 1'b0);
        check("rst_data", OUT_DATA, 32'h0);
        RST = 1'b0;
        #1;
        check("post_rst_cmd_ready", CMD_READY, 1'b1);
        check("post_rst_cnt", BURST_CNT, 16'h0);

        for (int i = 0; i < 4; i++) push_word();
        run_burst(3, 0, 0);
        check("thru_pops", ren_n, 4);
        check("thru_pop_span", ren_last - ren_first, 3);
        check("thru_words", fire_n, 4);
        check("thru_word_span", fire_last - fire_first, 3);

        for (int i = 0; i < 8; i++) push_word();
        run_burst(7, 1, 0);
        check("bp_words", fire_n, 8);
        check("bp_pops", ren_n, 8);

        run_burst(2, 0, 3);
        check("starve_words", fire_n, 3);
        check("starve_fifo_empty", FIFO_REMPTY, 1'b1);

        push_word();
        push_word();
        run_burst(0, 0, 0);
        check("len0_pops", ren_n, 1);
        check("len0_fifo_left", 8'(wr_ptr - rd_ptr), 8'd1);
        for (int i = 0; i < 15; i++) push_word();
        run_burst(15, 0, 0);
        check("len15_pops", ren_n, 16);
        check("len15_fifo_empty", FIFO_REMPTY, 1'b1);

        for (int i = 0; i < 4; i++) push_word();
        OUT_READY = 1'b0;
        issue_cmd(3);
        for (int n = 0; n < 20 && 8'(wr_ptr - rd_ptr) != 8'd2; n++) step();
        step();
        step();
        check("mid_fifo_left", 8'(wr_ptr - rd_ptr), 8'd2);
        RST = 1'b1;
        step();
        check("mid_rst_valid", OUT_VALID, 1'b0);
        check("mid_rst_cmd_ready", CMD_READY, 1'b0);
        RST = 1'b0;
        #1;
        check("mid_post_cmd_ready", CMD_READY, 1'b1);
        check("mid_post_cnt", BURST_CNT, 16'h0);
        check("mid_post_fifo_left", 8'(wr_ptr - rd_ptr), 8'd2);
        OUT_READY = 1'b1;

        run_burst(1, 0, 0);
        check("drain_words", fire_n, 2);
        push_word();
        run_burst(0, 1, 0);
        for (int i = 0; i < 3; i++) push_word();
        run_burst(2, 1, 0);
        step();
`ifdef MFP_FIFO_RD_STREAM_CNT_EN
        check("burst_cnt", BURST_CNT, 16'd3);
`else
        check("burst_cnt", BURST_CNT, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
